spi_reg_ctrl: RTL
=================

Name: spi_reg_ctrl

Overview:
- SPI slave transaction controller. Sequences the synchronized SCK/CS/MOSI receive datapath into command/data frames.
- Provides a bank of NUM_REGS 8-bit user registers, writable and readable over SPI.
- Sits between the board GPIO SPI pins and the user logic (LEDs, lab peripherals), replacing single-byte capture with addressed register access.
- SPI mode 0, MSB first, byte-oriented.

Parameters:
- NUM_REGS, 8, number of 8-bit registers (2..128).
- ADDR_W, 3, register address width; equals clog2(NUM_REGS).

Ports:
- sys_clk  in  1  system clock (50 MHz).
- sys_rst_n  in  1  reset.
- spi_sck  in  1  SPI clock, asynchronous.
- spi_cs_n  in  1  chip select, active-low, asynchronous.
- spi_mosi  in  1  master-out data, asynchronous.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable; high only while a frame is active.
- reg_out  out  NUM_REGS*8  flattened register bank; reg i at [8i+7:8i].
- wr_strobe  out  1  one-cycle pulse on each register commit.
- wr_addr  out  ADDR_W  address of the last committed register.
- frame_err  out  1  one-cycle pulse on a bad address or truncated frame.

Behaviour:
- Reset: sys_rst_n, asynchronous, active-low; clock sys_clk. All control state is reset asynchronously.
- Reset values: reg_out all 0; spi_miso 0; spi_miso_oe 0; wr_strobe 0; wr_addr 0; frame_err 0; FSM in IDLE.
- Synchronizers: SCK and CS use 3-flop synchronizers, reset to 000 and 111 respectively. MOSI uses a 2-flop synchronizer.
- Edge detection: sck_rise, sck_fall, cs_fall and cs_rise are derived from the last two synchronizer stages.
- SCK timing: each SCK half-period must be at least 4 sys_clk cycles.
- Receive: a bit is sampled on sck_rise into an 8-bit shift register; a 3-bit counter tracks bits within the byte.
- Command byte format:
  - bit7 = 1 means write, 0 means read.
  - bits[ADDR_W-1:0] are the address.
  - bits[6:ADDR_W] are ignored.
  - An address >= NUM_REGS is a bad address.
- FSM states:
  - IDLE: on cs_fall, clear the bit counter and go to CMD. spi_miso_oe rises in the same cycle.
  - CMD: on the 8th sck_rise, decode the byte.
    - Bad address: pulse frame_err and go to DONE.
    - Read: load the read shift register with reg[addr] and drive its MSB on spi_miso in the next cycle.
    - Either valid command: go to DATA.
  - DATA: on the 8th sck_rise the byte completes.
    - Write: reg[addr] <= received byte, pulse wr_strobe and update wr_addr in the same cycle.
    - Read: MISO shifts to the next bit on each sck_fall.
    - Then go to DONE (or stay in DATA, see Optional Feature).
  - DONE: ignore further SCK activity; spi_miso holds 0.
- In any state, cs_rise returns the FSM to IDLE and drops spi_miso_oe in the same cycle.
- Truncated frame: cs_rise in CMD or DATA with the bit counter nonzero, or in DATA before the byte completes, pulses frame_err. No register changes.
- Empty frame: cs_rise in CMD with zero bits received is not an error.
- spi_miso is 0 during CMD.
- Simultaneous cs_rise and 8th sck_rise in DATA: the byte completes and commits, then the FSM goes to IDLE, with no frame_err.
- Reset mid-frame: the FSM returns to IDLE. The master must restart the frame after CS toggles.
- A write to register A is visible on reg_out the cycle after wr_strobe. A read of A in a later frame returns the new value.

Optional Feature:
- Macro: SPI_AUTOINC_EN.
- Defined: after a DATA byte completes, the FSM stays in DATA with addr <= addr+1.
  - Address wraps from NUM_REGS-1 to 0.
  - Write bursts commit each byte with its own wr_strobe.
  - Read bursts reload the shift register from the next register.
- Undefined: after one DATA byte the FSM goes to DONE and extra bytes are ignored.

Decomposition:
- Package spi_reg_pkg:
  - FSM state enum (IDLE, CMD, DATA, DONE).
  - BYTE_W = 8.
  - CMD_WR_BIT = 7.
  - SYNC_STAGES_CTRL = 3, SYNC_STAGES_DATA = 2.
- Sub-module spi_sync_edge: parameterized synchronizer plus rise/fall detector with a reset value input. Instantiated for SCK and CS.

Test Plan:
- Write 0x82,0xA5 (reg2) -> one wr_strobe, wr_addr=2, reg_out[23:16]=0xA5, frame_err=0.
- Read after that write: 0x02,0x00 -> MISO bits during DATA = 1010_0101, spi_miso_oe high only while CS is low.
- Command 0x8F with NUM_REGS=8 (addr 7 valid) -> write commits. Command with addr 9 at ADDR_W=4, NUM_REGS=8 -> frame_err pulse, no wr_strobe.
- CS raised after 5 bits of DATA in write 0x81 -> frame_err pulse, reg1 unchanged. Next full frame succeeds.
- sys_rst_n asserted mid-DATA -> all outputs return to reset values. A following full frame works.
- SPI_AUTOINC_EN: write 0x86,0x11,0x22,0x33 -> reg6=0x11, reg7=0x22, reg0=0x33, three wr_strobes. Without the macro, only reg6 is written.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM encoding for the SPI register controller.
package spi_reg_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned CMD_WR_BIT       = 7;
    localparam int unsigned SYNC_STAGES_CTRL = 3;
    localparam int unsigned SYNC_STAGES_DATA = 2;

    // Frame sequencer states; plain constants keep the encoding visible to older tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CMD  = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall detection
// taken from the last two stages. The reset value sets the idle level of the line.
module spi_sync_edge #(
    parameter int unsigned STAGES = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rst_val,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{i_rst_val}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    // Edge pulses compare the two oldest stages.
    always_comb begin
        o_rise = r_sync[STAGES-2] & ~r_sync[STAGES-1];
        o_fall = ~r_sync[STAGES-2] & r_sync[STAGES-1];
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that frames command/data bytes into a bank of 8-bit registers.
// Optional build macro: SPI_AUTOINC_EN (burst access with auto-incrementing address).
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         spi_sck,
    input  logic                         spi_cs_n,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    output logic                         spi_miso_oe,
    output logic [NUM_REGS*BYTE_W-1:0]   reg_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES_CTRL)) u_sck_sync (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_rst_val (1'b0),
        .i_async   (spi_sck),
        .o_rise    (w_sck_rise),
        .o_fall    (w_sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES_CTRL)) u_cs_sync (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_rst_val (1'b1),
        .i_async   (spi_cs_n),
        .o_rise    (w_cs_rise),
        .o_fall    (w_cs_fall)
    );

    logic [SYNC_STAGES_DATA-1:0] r_mosi_sync;
    logic                        w_mosi;

    // MOSI needs one stage fewer so its output lines up with the SCK edge pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES_DATA-2:0], spi_mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES_DATA-1];

    state_t                      r_state;
    logic [2:0]                  r_bit_cnt;
    logic [BYTE_W-1:0]           r_shift_rx;
    logic [BYTE_W-1:0]           r_shift_tx;
    logic [ADDR_W-1:0]           r_addr;
    logic                        r_is_wr;
    logic                        r_data_got;
    logic                        r_miso;
    logic                        r_miso_oe;
    logic                        r_wr_strobe;
    logic [ADDR_W-1:0]           r_wr_addr;
    logic                        r_frame_err;
    logic [NUM_REGS*BYTE_W-1:0]  r_regs;

    logic [BYTE_W-1:0]           w_rx_byte;
    logic                        w_byte_done;
    logic [ADDR_W-1:0]           w_cmd_addr;
    logic                        w_bad_addr;
    logic                        w_commit;
    logic [BYTE_W-1:0]           w_rd_cmd;

    assign w_rx_byte   = {r_shift_rx[BYTE_W-2:0], w_mosi};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
    assign w_cmd_addr  = w_rx_byte[ADDR_W-1:0];
    assign w_bad_addr  = (32'(w_cmd_addr) >= NUM_REGS);
    assign w_commit    = (r_state == ST_DATA) && w_byte_done && r_is_wr;

    // Read mux for the address carried in the command byte.
    always_comb begin
        w_rd_cmd = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(w_cmd_addr) == 32'(i)) w_rd_cmd = r_regs[i*BYTE_W +: BYTE_W];
        end
    end

`ifdef SPI_AUTOINC_EN
    logic [ADDR_W-1:0] w_next_addr;
    logic [BYTE_W-1:0] w_rd_next;

    // Next burst address (wrapping at the top of the bank) and its read data.
    always_comb begin
        w_next_addr = (32'(r_addr) == NUM_REGS - 1) ? '0 : r_addr + ADDR_W'(1);
        w_rd_next   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(w_next_addr) == 32'(i)) w_rd_next = r_regs[i*BYTE_W +: BYTE_W];
        end
    end
`endif

    // Register bank: commit the received data byte to the addressed register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_regs <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (32'(r_addr) == 32'(i)) r_regs[i*BYTE_W +: BYTE_W] <= w_rx_byte;
            end
        end
    end

    // Frame sequencer: bit counting, command decode, MISO shifting and status pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift_rx  <= '0;
            r_shift_tx  <= '0;
            r_addr      <= '0;
            r_is_wr     <= 1'b0;
            r_data_got  <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_sck_rise && (r_state == ST_CMD || r_state == ST_DATA)) begin
                r_shift_rx <= w_rx_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            if (w_commit) begin
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_addr;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_bit_cnt <= 3'd0;
                        r_miso    <= 1'b0;
                        r_miso_oe <= 1'b1;
                        r_state   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_cs_rise) begin
                        // An empty frame is legal; a partial command byte is not.
                        r_frame_err <= (r_bit_cnt != 3'd0);
                        r_miso      <= 1'b0;
                        r_miso_oe   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_byte_done) begin
                        if (w_bad_addr) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_addr     <= w_cmd_addr;
                            r_is_wr    <= w_rx_byte[CMD_WR_BIT];
                            r_data_got <= 1'b0;
                            r_state    <= ST_DATA;
                            if (!w_rx_byte[CMD_WR_BIT]) begin
                                r_shift_tx <= w_rd_cmd;
                                r_miso     <= w_rd_cmd[BYTE_W-1];
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_byte_done) begin
                        r_data_got <= 1'b1;
`ifdef SPI_AUTOINC_EN
                        r_addr <= w_next_addr;
                        if (!r_is_wr) begin
                            r_shift_tx <= w_rd_next;
                            r_miso     <= w_rd_next[BYTE_W-1];
                        end
`else
                        r_miso  <= 1'b0;
                        r_state <= ST_DONE;
`endif
                    end else if (w_sck_fall && !r_is_wr && (r_bit_cnt != 3'd0)) begin
                        // The fall right after a byte boundary keeps the freshly loaded MSB.
                        r_shift_tx <= {r_shift_tx[BYTE_W-2:0], 1'b0};
                        r_miso     <= r_shift_tx[BYTE_W-2];
                    end
                    if (w_cs_rise) begin
                        r_frame_err <= !w_byte_done && ((r_bit_cnt != 3'd0) || !r_data_got);
                        r_miso      <= 1'b0;
                        r_miso_oe   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    if (w_cs_rise) begin
                        r_miso    <= 1'b0;
                        r_miso_oe <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign reg_out     = r_regs;
    assign wr_strobe   = r_wr_strobe;
    assign wr_addr     = r_wr_addr;
    assign frame_err   = r_frame_err;

endmodule
